// File: rtl/z16_fetch_ctrl.sv
// z16_fetch_ctrl: instruction fetch controller with an IDLE/RUN/HALT FSM,
// a 2-entry {pc, instr} prefetch buffer and redirect flush.
`default_nettype none

module z16_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_halt,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_instr,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic [1:0]  o_state,
  output logic [1:0]  o_count
);

  localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e      state_q;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [15:0] ins0_q, ins0_d, ins1_q, ins1_d;
  logic        pop, push;

  assign o_instr_valid = (count_q != 2'd0);
  assign pop           = o_instr_valid & i_instr_ready;
  assign push          = (state_q == ST_RUN) & ~i_redirect & ~i_halt &
                         ((count_q < 2'd2) | pop);

  assign o_imem_addr = fetch_pc_q;
  assign o_instr     = o_instr_valid ? ins0_q : 16'h0000;
  assign o_pc        = o_instr_valid ? pc0_q  : 16'h0000;
  assign o_state     = state_q;
  assign o_count     = count_q;

  // Entry 0 is always the head; a pop shifts entry 1 down into it.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;
    ins0_d     = ins0_q;
    ins1_d     = ins1_q;
    if (i_redirect) begin
      count_d    = 2'd0;
      fetch_pc_d = i_redirect_pc & 16'hFFFE;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 16'd2;
      end
      if (push && pop) begin
        if (count_q == 2'd2) begin
          pc0_d  = pc1_q;
          ins0_d = ins1_q;
          pc1_d  = fetch_pc_q;
          ins1_d = i_imem_instr;
        end else begin
          pc0_d  = fetch_pc_q;
          ins0_d = i_imem_instr;
        end
      end else if (push) begin
        if (count_q == 2'd0) begin
          pc0_d  = fetch_pc_q;
          ins0_d = i_imem_instr;
        end else begin
          pc1_d  = fetch_pc_q;
          ins1_d = i_imem_instr;
        end
        count_d = count_q + 2'd1;
      end else if (pop) begin
        pc0_d   = pc1_q;
        ins0_d  = ins1_q;
        count_d = count_q - 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc_q <= RESET_PC_ALIGNED;
      count_q    <= 2'd0;
      pc0_q      <= 16'h0000;
      pc1_q      <= 16'h0000;
      ins0_q     <= 16'h0000;
      ins1_q     <= 16'h0000;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
      ins0_q     <= ins0_d;
      ins1_q     <= ins1_d;
    end
  end

  // A redirect blocks start; only halt-in-RUN may still change state with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (i_start && !i_redirect) state_q <= ST_RUN;
        ST_RUN:  if (i_halt)                 state_q <= ST_HALT;
        ST_HALT: if (i_start && !i_redirect) state_q <= ST_RUN;
        default:                             state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_z16_fetch_ctrl.sv
// tb_z16_fetch_ctrl: scoreboard bench for z16_fetch_ctrl with directed
// scenarios, random traffic and an asynchronous mid-cycle reset.
`default_nettype none

module tb_z16_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, redir, ready;
  logic [15:0] rpc;
  logic [15:0] imem_addr, imem_data, instr, pc;
  logic        valid;
  logic [1:0]  state, count;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [1:0]  mst;
  logic [15:0] mpc;

  always #5 clk = ~clk;

  function automatic logic [15:0] imem(input logic [15:0] a);
    case (a)
      16'h0000: imem = 16'h0040;
      16'h0002: imem = 16'h0050;
      16'h0004: imem = 16'h0080;
      default:  imem = a ^ 16'hC3A5;
    endcase
  endfunction

  always_comb imem_data = imem(imem_addr);

  z16_fetch_ctrl #(.RESET_PC(16'h0001)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_halt        (halt),
    .i_redirect    (redir),
    .i_redirect_pc (rpc),
    .o_imem_addr   (imem_addr),
    .i_imem_instr  (imem_data),
    .o_instr_valid (valid),
    .i_instr_ready (ready),
    .o_instr       (instr),
    .o_pc          (pc),
    .o_state       (state),
    .o_count       (count)
  );

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("count", {14'd0, count}, 16'(mq.size()));
    check_eq("valid", {15'd0, valid}, {15'd0, (mq.size() != 0)});
    check_eq("addr", imem_addr, mpc);
    check_eq("state", {14'd0, state}, {14'd0, mst});
    if (mq.size() != 0) begin
      check_eq("head_pc", pc, mq[0].pc);
      check_eq("head_instr", instr, mq[0].ins);
    end else begin
      check_eq("empty_pc", pc, 16'h0000);
      check_eq("empty_instr", instr, 16'h0000);
    end
  endtask

  // Checks outputs, then advances one edge while updating the reference model.
  task automatic cycle();
    logic m_pop, m_push;
    ent_t e;
    #1;
    check_outputs();
    m_pop  = (mq.size() != 0) && ready;
    m_push = (mst == 2'd1) && !redir && !halt && ((mq.size() < 2) || m_pop);
    e      = '{pc: mpc, ins: imem(mpc)};
    @(posedge clk);
    if (redir) begin
      mq.delete();
      mpc = rpc & 16'hFFFE;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back(e);
        mpc = mpc + 16'd2;
      end
    end
    case (mst)
      2'd0: if (start && !redir) mst = 2'd1;
      2'd1: if (halt) mst = 2'd2;
      2'd2: if (start && !redir) mst = 2'd1;
      default: mst = 2'd0;
    endcase
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    mst = 2'd0;
    mpc = 16'h0000;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; halt = 0; redir = 0; ready = 0; rpc = 16'h0000;
    model_reset();
    #3;
    check_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // No fetch before start
    repeat (2) cycle();

    // Basic streaming
    ready = 1; start = 1;
    cycle();
    start = 0;
    cycle();
    check_eq("s34_instr0", instr, 16'h0040);
    check_eq("s34_pc0", pc, 16'h0000);
    cycle();
    check_eq("s34_instr1", instr, 16'h0050);
    check_eq("s34_pc1", pc, 16'h0002);
    cycle();
    check_eq("s34_instr2", instr, 16'h0080);
    check_eq("s34_pc2", pc, 16'h0004);

    // Backpressure
    ready = 0; redir = 1; rpc = 16'h0000;
    cycle();
    redir = 0;
    repeat (5) cycle();
    check_eq("s35_count", {14'd0, count}, 16'd2);
    check_eq("s35_addr", imem_addr, 16'h0004);
    check_eq("s35_pc_hold", pc, 16'h0000);
    ready = 1;
    cycle();
    check_eq("s35_pc1", pc, 16'h0002);
    cycle();
    check_eq("s35_pc2", pc, 16'h0004);

    // Redirect with full buffer
    ready = 0;
    cycle();
    redir = 1; rpc = 16'h0013;
    cycle();
    redir = 0;
    check_eq("s36_count", {14'd0, count}, 16'd0);
    check_eq("s36_addr", imem_addr, 16'h0012);
    ready = 1;
    cycle();
    check_eq("s36_pc", pc, 16'h0012);

    // Halt with one entry, drain, resume
    halt = 1;
    cycle();
    halt = 0;
    check_eq("s37_state", {14'd0, state}, 16'd2);
    repeat (2) cycle();
    check_eq("s37_valid", {15'd0, valid}, 16'd0);
    check_eq("s37_addr", imem_addr, 16'h0014);
    start = 1;
    cycle();
    start = 0;
    cycle();
    check_eq("s37_resume_pc", pc, 16'h0014);

    // Wrap at top of address space
    redir = 1; rpc = 16'hFFFE;
    cycle();
    redir = 0;
    cycle();
    check_eq("s38_pc_top", pc, 16'hFFFE);
    cycle();
    check_eq("s38_pc_wrap", pc, 16'h0000);

    // Redirect and halt together
    redir = 1; halt = 1; rpc = 16'h0101;
    cycle();
    redir = 0; halt = 0;
    check_eq("s27_state", {14'd0, state}, 16'd2);
    check_eq("s27_addr", imem_addr, 16'h0100);
    start = 1;
    cycle();
    start = 0;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 7) == 0);
      halt  = ($urandom_range(0, 15) == 0);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = 16'($urandom);
      cycle();
    end

    // Asynchronous reset with full buffer
    start = 1; halt = 0; redir = 0; ready = 0;
    cycle();
    start = 0;
    repeat (3) cycle();
    check_eq("s39_pre_count", {14'd0, count}, 16'd2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("s39_addr", imem_addr, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready = 1;
    repeat (3) cycle();
    start = 1;
    cycle();
    start = 0;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/z16_fetch_ctrl.md
Z16_FETCH_CTRL -- requirements
Module: z16_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the fetch PC loaded at reset (bit0 ignored).
REQ-002 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_start  input  1  start/resume fetching pulse.
REQ-005 SHALL have port i_halt  input  1  stop-fetch request from decode.
REQ-006 SHALL have port i_redirect  input  1  branch/jump redirect strobe.
REQ-007 SHALL have port i_redirect_pc  input  16  redirect target byte address.
REQ-008 SHALL have port o_imem_addr  output  16  byte address to the instruction memory.
REQ-009 SHALL have port i_imem_instr  input  16  instruction word, combinational from o_imem_addr in the same cycle.
REQ-010 SHALL have port o_instr_valid  output  1  buffer head holds a valid instruction.
REQ-011 SHALL have port i_instr_ready  input  1  decode accepts the head entry.
REQ-012 SHALL have port o_instr  output  16  head instruction.
REQ-013 SHALL have port o_pc  output  16  byte address of the head instruction.
REQ-014 SHALL have port o_state  output  2  FSM state: 0 IDLE, 1 RUN, 2 HALT.
REQ-015 SHALL have port o_count  output  2  buffer occupancy, 0..2.

Function
REQ-016 SHALL hold a 16-bit fetch_pc register with bit0 always 0; o_imem_addr = fetch_pc combinationally.
REQ-017 SHALL hold a 2-entry FIFO of {pc, instr} pairs; o_instr/o_pc show the head entry, and are 16'h0000 when the FIFO is empty.
REQ-018 SHALL define pop = o_instr_valid & i_instr_ready, with o_instr_valid = (count != 0).
REQ-019 SHALL define push = (state == RUN) & ~i_redirect & ~i_halt & ((count < 2) | pop).
REQ-020 SHALL, on push, write {fetch_pc, i_imem_instr} at the tail and increment fetch_pc by 2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
REQ-021 SHALL support a simultaneous push and pop at count 2 or count 1, leaving count unchanged.
REQ-022 SHALL go from IDLE to RUN on i_start and otherwise stay in IDLE; no fetch occurs in IDLE.
REQ-023 SHALL go from RUN to HALT on i_halt; no push occurs in that cycle.
REQ-024 SHALL go from HALT to RUN on i_start, resuming at the current fetch_pc, and ignore i_start in RUN.
REQ-025 SHALL keep draining the FIFO via pop in every state, including HALT and IDLE.
REQ-026 SHALL, on i_redirect in any state, empty the FIFO (count to 0, any pop that cycle discarded) and load fetch_pc = {i_redirect_pc[15:1], 1'b0}; no push occurs that cycle, and the state is unchanged except for the transitions in REQ-027.
REQ-027 SHALL, on i_redirect and i_halt together in RUN, apply both the flush/load and the RUN-to-HALT transition.
REQ-028 SHALL have a latency of one edge from a push to o_instr_valid=1: with i_start sampled at edge E0, the first push is at E1 and o_instr_valid=1 after E1.
REQ-029 SHALL keep steady-state throughput at 1 instruction/cycle while i_instr_ready=1.
REQ-030 SHALL never drop or duplicate an entry under i_instr_ready backpressure; with count=2 and no pop, fetch_pc holds.

Reset
REQ-031 SHALL, while i_rst_n=0, asynchronously force: state IDLE, fetch_pc RESET_PC with bit0 cleared, FIFO count 0, o_instr_valid 0, o_instr 0, o_pc 0, o_count 0, o_state 0.
REQ-032 SHALL, on reset asserted mid-operation, discard all FIFO contents and resume only from IDLE after release.
REQ-033 SHALL require an i_start after reset deassertion before any fetch.

Verification
REQ-034 SHALL cover this scenario: reset, i_start, i_instr_ready=1, memory words 0040,0050,0080 -> o_instr 0040/0050/0080 with o_pc 0000/0002/0004 on consecutive cycles; o_instr_valid first high one edge after the first push.
REQ-035 SHALL cover this scenario: RUN with i_instr_ready=0 for 5 cycles -> o_count saturates at 2, o_imem_addr holds at 0004, head stays o_pc=0000; on ready=1, o_pc sequence 0000, 0002, 0004 with no gaps or repeats.
REQ-036 SHALL cover this scenario: i_redirect with i_redirect_pc=0013 while count=2 -> count 0 next cycle, o_imem_addr=0012, next o_pc delivered=0012.
REQ-037 SHALL cover this scenario: i_halt in RUN with count=1 -> o_state=2, no further push, the entry drains, o_instr_valid=0; then i_start -> fetching resumes at the held fetch_pc.
REQ-038 SHALL cover this scenario: redirect to FFFE, ready=1 -> o_pc FFFE then 0000 (wrap).
REQ-039 SHALL cover this scenario: i_rst_n asserted asynchronously mid-cycle with count=2 -> all outputs zero immediately, o_imem_addr=RESET_PC, state IDLE until i_start.
